// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: reset/enable levels, the
// zero word, and the 2-bit encodings of the responder FSM.
package dmem_responder_pkg;

  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;

  localparam logic [1:0] DMEM_IDLE = 2'b00;
  localparam logic [1:0] DMEM_BUSY = 2'b01;
  localparam logic [1:0] DMEM_DONE = 2'b10;

endpackage

// File: rtl/dmem_responder_ram_1p.sv
// Single-port word RAM with four byte-lane write enables and a registered read
// port; the read register only updates on an enabled read, so it holds the last load.
module dmem_ram_1p #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one LSU request, waits WAIT_CYCLES, commits it
// to the on-chip RAM (or flags it out of window) and stalls the pipeline meanwhile.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   DMEM_IDLE | no access in flight; stall follows mem_ce_i combinationally
//   DMEM_BUSY | request latched; counting wait states, commits when cnt==0
//   DMEM_DONE | result/error valid; stall released; back to IDLE next cycle
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stall_req_o,
  output logic        access_err_o
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  req_we;
  logic [3:0]            req_sel;
  logic [31:2]           req_addr;
  logic [31:0]           req_data;
  logic                  data_zero;
  logic                  err_q;
  logic                  commit;
  logic                  in_window;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_lsb;

  // Byte-lane selection is the LSU's job, so the low address bits are dropped.
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  // BASE_ADDR is window-aligned, so the window test is a tag compare and the
  // word index falls straight out of the address.
  assign in_window = (req_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign word_idx  = req_addr[ADDR_WIDTH+1:2];
  assign commit    = (state == DMEM_BUSY) && (cnt == 4'd0);
  assign ram_en    = commit && in_window;

  dmem_ram_1p #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (req_we == WRITE_ENABLE),
    .be    (req_sel),
    .addr  (word_idx),
    .wdata (req_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (n_rst_i == RST_ENABLE) begin
      state     <= DMEM_IDLE;
      cnt       <= 4'd0;
      req_we    <= 1'b0;
      req_sel   <= 4'b0000;
      req_addr  <= '0;
      req_data  <= ZERO_WORD;
      data_zero <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        DMEM_IDLE: begin
          if (mem_ce_i == CHIP_ENABLE) begin
            req_we   <= mem_we_i;
            req_sel  <= mem_sel_i;
            req_addr <= mem_addr_i[31:2];
            req_data <= mem_data_i;
            cnt      <= CNT_INIT;
            state    <= DMEM_BUSY;
          end
        end
        DMEM_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            err_q <= !in_window;
            if (req_we != WRITE_ENABLE) data_zero <= !in_window;
            state <= DMEM_DONE;
          end
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end

  // Stall is forced low while reset is asserted, even with a request present.
  always_comb begin
    stall_req_o = 1'b0;
    if (n_rst_i != RST_ENABLE) begin
      case (state)
        DMEM_IDLE: stall_req_o = (mem_ce_i == CHIP_ENABLE);
        DMEM_BUSY: stall_req_o = 1'b1;
        default:   stall_req_o = 1'b0;
      endcase
    end
  end

  assign mem_data_o   = data_zero ? ZERO_WORD : ram_rdata;
  assign access_err_o = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with
// three, driven from a shared input bus with separate chip enables.
module tb_dmem_responder;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        ce1, ce3;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [31:0] data1, data3;
  logic        stall1, stall3, err1, err3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .mem_ce_i(ce1), .mem_we_i(mem_we_i),
    .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_data_o(data1), .stall_req_o(stall1), .access_err_o(err1)
  );

  dmem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .mem_ce_i(ce3), .mem_we_i(mem_we_i),
    .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_data_o(data3), .stall_req_o(stall3), .access_err_o(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    ce1 = 1'b0;
    ce3 = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  // Starts at a negedge; returns at the negedge of the DONE cycle with the
  // request still asserted, so a following call forms a back-to-back access.
  task automatic access(input string tag, input bit use3, input logic we,
                        input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_err, input bit scramble,
                        input logic [31:0] scr_addr);
    int n;
    bit started, done;
    logic s;
    n = 0; started = 0; done = 0;
    if (use3) ce3 = 1'b1; else ce1 = 1'b1;
    mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_data_i = wdata;
    #1;
    s = use3 ? stall3 : stall1;
    if (s) begin n = 1; started = 1; end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      s = use3 ? stall3 : stall1;
      if (s) begin
        n++;
        started = 1;
        if (scramble && n == 2) begin
          mem_we_i = ~we; mem_sel_i = 4'hF; mem_addr_i = scr_addr; mem_data_i = 32'hFFFF_FFFF;
        end
      end else if (started) begin
        done = 1;
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall"}, 32'(n), use3 ? 32'd4 : 32'd2);
    chk({tag, " data"}, use3 ? data3 : data1, exp_data);
    chk({tag, " err"}, 32'(use3 ? err3 : err1), 32'(exp_err));
  endtask

  initial begin
    n_rst_i = 1'b0;
    ce1 = 1'b0; ce3 = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
    mem_addr_i = 32'h0; mem_data_i = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("rst stall1", 32'(stall1), 32'd0);
    chk("rst data1", data1, 32'h0);
    chk("rst err1", 32'(err1), 32'd0);
    chk("rst stall3", 32'(stall3), 32'd0);
    chk("rst data3", data3, 32'h0);
    n_rst_i = 1'b1;
    idle(2);

    // one wait state: basic store/load, byte lanes, sel=0
    access("sw deadbeef", 0, 1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    access("lw deadbeef", 0, 0, 4'hF, 32'h0001_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    idle(1);
    access("sb lane1", 0, 1, 4'b0010, 32'h0001_0011, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 0, 0, 0);
    access("lw merged", 0, 0, 4'b0001, 32'h0001_0010, 32'h0, 32'hDEAD_A5EF, 0, 0, 0);
    access("sw sel0", 0, 1, 4'b0000, 32'h0001_0010, 32'h0000_0000, 32'hDEAD_A5EF, 0, 0, 0);
    access("lw after sel0", 0, 0, 4'hF, 32'h0001_0010, 32'h0, 32'hDEAD_A5EF, 0, 0, 0);

    // window boundaries
    access("lw below", 0, 0, 4'hF, 32'h0000_0000, 32'h0, 32'h0, 1, 0, 0);
    idle(1);
    chk("err one cycle", 32'(err1), 32'd0);
    access("sw word0", 0, 1, 4'hF, 32'h0001_0000, 32'h0BAD_C0DE, 32'h0, 0, 0, 0);
    access("sw last", 0, 1, 4'hF, 32'h0001_3FFC, 32'h1234_5678, 32'h0, 0, 0, 0);
    access("sw past", 0, 1, 4'hF, 32'h0001_4000, 32'hCAFE_F00D, 32'h0, 1, 0, 0);
    access("lw word0", 0, 0, 4'hF, 32'h0001_0000, 32'h0, 32'h0BAD_C0DE, 0, 0, 0);
    access("lw last", 0, 0, 4'hF, 32'h0001_3FFC, 32'h0, 32'h1234_5678, 0, 0, 0);
    access("lw just below", 0, 0, 4'hF, 32'h0000_FFFC, 32'h0, 32'h0, 1, 0, 0);
    idle(2);

    // three wait states, back to back, inputs disturbed during BUSY
    access("w3 sw a", 1, 1, 4'hF, 32'h0001_0020, 32'h1122_3344, 32'h0, 0, 0, 0);
    access("w3 sw b", 1, 1, 4'hF, 32'h0001_0024, 32'h5566_7788, 32'h0, 0, 0, 0);
    access("w3 lw a", 1, 0, 4'hF, 32'h0001_0020, 32'h0, 32'h1122_3344, 0, 1, 32'h0001_0024);
    access("w3 lw b", 1, 0, 4'hF, 32'h0001_0024, 32'h0, 32'h5566_7788, 0, 0, 0);
    access("w3 sw c", 1, 1, 4'hF, 32'h0001_0028, 32'h99AA_BBCC, 32'h5566_7788, 0, 1, 32'h0001_0020);
    access("w3 lw c", 1, 0, 4'hF, 32'h0001_0028, 32'h0, 32'h99AA_BBCC, 0, 0, 0);
    access("w3 lw a2", 1, 0, 4'hF, 32'h0001_0020, 32'h0, 32'h1122_3344, 0, 0, 0);
    idle(2);

    // reset during BUSY of a store drops the write
    access("pre sw", 0, 1, 4'hF, 32'h0001_0100, 32'h1111_2222, 32'h0, 0, 0, 0);
    idle(1);
    ce1 = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
    mem_addr_i = 32'h0001_0100; mem_data_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    chk("busy before rst", 32'(stall1), 32'd1);
    n_rst_i = 1'b0;
    #1;
    chk("stall in rst", 32'(stall1), 32'd0);
    chk("data in rst", data1, 32'h0);
    chk("err in rst", 32'(err1), 32'd0);
    ce1 = 1'b0;
    @(negedge clk_i);
    n_rst_i = 1'b1;
    idle(2);
    access("lw after rst", 0, 0, 4'hF, 32'h0001_0100, 32'h0, 32'h1111_2222, 0, 0, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
